clock_control_fsm: RTL and testbench
====================================

// Module: clock_control_fsm
// PURPOSE
//  User-interface sequencer for the HH:MM:SS timer core.
//  Turns debounced, clk-synchronous push-button levels into the timer's control inputs:
//   - start_timer: run/pause level.
//   - adjust_minutes / adjust_hours: single-cycle increment pulses.
//  Also drives a blink enable that the display path uses to flash the field being set.
// PARAMETERS
//  T_REPEAT_DELAY   50_000_000  cycles btn_inc must be held before the first auto-repeat pulse
//  T_REPEAT_PERIOD  10_000_000  cycles between later auto-repeat pulses
//  T_BLINK          25_000_000  half-period of blink in set modes
//  T_IDLE          1_000_000_000 cycles with no button edge in a set mode before auto-return to RUN
//  Counter widths are $clog2 of each parameter. Every parameter must be >= 2.
// PORTS
//  clk             in   1  system clock
//  rst             in   1  synchronous, active-high reset
//  btn_run         in   1  debounced level; rising edge toggles run/pause
//  btn_mode        in   1  debounced level; rising edge steps RUN->SET_MIN->SET_HOUR->RUN
//  btn_inc         in   1  debounced level; increments the selected field
//  start_timer     out  1  level to timer; 1 = seconds advance
//  adjust_minutes  out  1  one-cycle pulse: +1 minute
//  adjust_hours    out  1  one-cycle pulse: +1 hour
//  mode            out  2  00 RUN, 01 SET_MIN, 10 SET_HOUR (11 never driven)
//  blink           out  1  1 = selected field visible; 0 = blanked
// BEHAVIOUR
//  - Reset values: all outputs are registered.
//    - start_timer=0, adjust_*=0, mode=00, blink=1.
//    - Internal run flag=0; all counters=0; edge-detect history=0.
//  - Edge detect: rise_x = x & ~x_q. A button already high at reset release gives no edge.
//  - FSM states: RUN, SET_MIN, SET_HOUR.
//    - btn_mode rise: RUN->SET_MIN->SET_HOUR->RUN.
//    - SET_MIN or SET_HOUR with idle count reaching T_IDLE-1: go to RUN.
//  - Run flag: btn_run rise toggles it in RUN only; ignored in set modes.
//  - start_timer = run flag & (state==RUN). The clock freezes while being set.
//    On return to RUN the previous run flag is restored.
//  - Increment, SET_MIN / SET_HOUR only:
//    - btn_inc rise at cycle N: adjust_minutes (SET_MIN) or adjust_hours (SET_HOUR) is high in cycle N+1 only.
//    - btn_inc rise in RUN: no pulse.
//  - Auto-repeat:
//    - Hold counter clears on the btn_inc rise and counts every cycle btn_inc stays 1.
//    - First repeat pulse comes T_REPEAT_DELAY cycles after the initial pulse.
//    - Later pulses come every T_REPEAT_PERIOD cycles.
//    - btn_inc falling clears the counter immediately. No pulse is emitted on release.
//  - Pulses are never issued in consecutive cycles; the timer core needs one idle cycle between adjusts.
//  - Simultaneous events:
//    - btn_mode rise with btn_inc rise (or a repeat due): mode change wins, no adjust pulse.
//    - The hold counter clears on every mode change; btn_inc must be re-pressed.
//  - Idle counter: clears on any rise of btn_mode, btn_inc or btn_run, on every repeat pulse, and in RUN.
//    It saturates at T_IDLE-1.
//  - Blink:
//    - RUN: blink=1.
//    - On entering a set mode: blink=1, then toggles every T_BLINK cycles.
//    - Any adjust pulse forces blink=1 and restarts the blink counter.
//  - Reset mid-operation: rst in any cycle gives the reset values on the next edge.
//    A pulse already in flight is dropped.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: auto-repeat as above.
//  Not defined: exactly one pulse per btn_inc press. T_REPEAT_* are unused and the hold counter is not built.
// TESTING
//  Use T_REPEAT_DELAY=20, T_REPEAT_PERIOD=5, T_BLINK=4, T_IDLE=100.
//  1 rst 3 cycles, release -> start_timer=0, mode=00, blink=1, no adjust pulses; btn_run rise -> start_timer=1 next cycle.
//  2 RUN running; btn_mode rise -> mode=01, start_timer=0; btn_inc 1-cycle press at N -> adjust_minutes=1 at N+1 only.
//  3 SET_HOUR, btn_inc held 40 cycles, AUTO_REPEAT_EN -> pulses at N+1, +20, +25, +30, +35 (5 total); without macro -> 1 pulse.
//  4 SET_MIN, no buttons 100 cycles -> mode=00; start_timer restored to the pre-set value.
//  5 btn_mode and btn_inc rise same cycle in SET_MIN -> mode=10, zero adjust pulses.
//  6 rst asserted mid repeat burst in SET_HOUR -> next cycle mode=00, adjust_hours=0, start_timer=0, blink=1.

Source files
------------

// File: rtl/clock_control_fsm.sv
// clock_control_fsm: push-button sequencer for the HH:MM:SS timer core (run/pause, field set, blink).
// Optional feature: define AUTO_REPEAT_EN to auto-repeat increments while btn_inc is held.
module clock_control_fsm #(
  parameter int unsigned T_REPEAT_DELAY  = 50_000_000,
  parameter int unsigned T_REPEAT_PERIOD = 10_000_000,
  parameter int unsigned T_BLINK         = 25_000_000,
  parameter int unsigned T_IDLE          = 1_000_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       start_timer,
  output logic       adjust_minutes,
  output logic       adjust_hours,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_MIN  = 2'b01,
    ST_SET_HOUR = 2'b10
  } state_t;

  localparam int BLINK_W = $clog2(T_BLINK);
  localparam int IDLE_W  = $clog2(T_IDLE);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(T_BLINK - 32'd1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(T_IDLE - 32'd1);

  if (T_REPEAT_DELAY < 32'd2 || T_REPEAT_PERIOD < 32'd2 || T_BLINK < 32'd2 || T_IDLE < 32'd2) begin : g_param_check
    $error("clock_control_fsm: every timing parameter must be >= 2");
  end

  state_t state_r, next_state_s;
  logic   run_flag_r, run_flag_next_s;
  logic   run_q_r, mode_q_r, inc_q_r, hist_valid_r;
  logic   run_rise_s, mode_rise_s, inc_rise_s, any_rise_s;
  logic   in_set_s, mode_chg_s, idle_done_s, repeat_due_s, inc_req_s;
  logic [IDLE_W-1:0]  idle_cnt_r;
  logic [BLINK_W-1:0] blink_cnt_r;

  // Edge detection, next state, run flag and adjust request
  always_comb begin
    // history is not trusted in the first cycle after reset, so a held button gives no edge
    run_rise_s  = hist_valid_r & btn_run  & ~run_q_r;
    mode_rise_s = hist_valid_r & btn_mode & ~mode_q_r;
    inc_rise_s  = hist_valid_r & btn_inc  & ~inc_q_r;
    any_rise_s  = run_rise_s | mode_rise_s | inc_rise_s;
    in_set_s    = (state_r != ST_RUN);
    idle_done_s = in_set_s & (idle_cnt_r == IDLE_LAST) & ~any_rise_s & ~repeat_due_s;
    next_state_s = state_r;
    if (mode_rise_s) begin
      case (state_r)
        ST_RUN:      next_state_s = ST_SET_MIN;
        ST_SET_MIN:  next_state_s = ST_SET_HOUR;
        ST_SET_HOUR: next_state_s = ST_RUN;
        default:     next_state_s = ST_RUN;
      endcase
    end else if (idle_done_s) begin
      next_state_s = ST_RUN;
    end else begin
      next_state_s = state_r;
    end
    mode_chg_s      = (next_state_s != state_r);
    run_flag_next_s = run_flag_r ^ (run_rise_s & ~in_set_s);
    inc_req_s       = in_set_s & ~mode_rise_s & (inc_rise_s | repeat_due_s)
                      & ~(adjust_minutes | adjust_hours);
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned HOLD_MAX = (T_REPEAT_DELAY > T_REPEAT_PERIOD) ? T_REPEAT_DELAY : T_REPEAT_PERIOD;
  localparam int HOLD_W = $clog2(HOLD_MAX);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(T_REPEAT_DELAY - 32'd1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(T_REPEAT_PERIOD - 32'd1);

  logic [HOLD_W-1:0] hold_cnt_r;
  logic              hold_armed_r, repeating_r;

  // Repeat falls due after the initial delay, then once per period
  always_comb begin
    if (repeating_r) begin
      repeat_due_s = hold_armed_r & btn_inc & (hold_cnt_r == PERIOD_LAST);
    end else begin
      repeat_due_s = hold_armed_r & btn_inc & (hold_cnt_r == DELAY_LAST);
    end
  end

  // Hold counter: armed by an accepted press, dropped on release or any mode change
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_armed_r <= 1'b0;
      repeating_r  <= 1'b0;
      hold_cnt_r   <= {HOLD_W{1'b0}};
    end else if (inc_rise_s & in_set_s & ~mode_chg_s) begin
      hold_armed_r <= 1'b1;
      repeating_r  <= 1'b0;
      hold_cnt_r   <= {HOLD_W{1'b0}};
    end else if (mode_chg_s | ~btn_inc) begin
      hold_armed_r <= 1'b0;
      repeating_r  <= 1'b0;
      hold_cnt_r   <= {HOLD_W{1'b0}};
    end else if (repeat_due_s) begin
      repeating_r  <= 1'b1;
      hold_cnt_r   <= {HOLD_W{1'b0}};
    end else if (hold_armed_r) begin
      hold_cnt_r   <= hold_cnt_r + HOLD_W'(1'b1);
    end else begin
      hold_cnt_r   <= hold_cnt_r;
    end
  end
`else
  assign repeat_due_s = 1'b0;
`endif

  // State, run flag, edge history, idle/blink counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_RUN;
      run_flag_r     <= 1'b0;
      run_q_r        <= 1'b0;
      mode_q_r       <= 1'b0;
      inc_q_r        <= 1'b0;
      hist_valid_r   <= 1'b0;
      idle_cnt_r     <= {IDLE_W{1'b0}};
      blink_cnt_r    <= {BLINK_W{1'b0}};
      start_timer    <= 1'b0;
      adjust_minutes <= 1'b0;
      adjust_hours   <= 1'b0;
      mode           <= 2'b00;
      blink          <= 1'b1;
    end else begin
      run_q_r        <= btn_run;
      mode_q_r       <= btn_mode;
      inc_q_r        <= btn_inc;
      hist_valid_r   <= 1'b1;
      state_r        <= next_state_s;
      run_flag_r     <= run_flag_next_s;
      mode           <= next_state_s;
      start_timer    <= run_flag_next_s & (next_state_s == ST_RUN);
      adjust_minutes <= inc_req_s & (state_r == ST_SET_MIN);
      adjust_hours   <= inc_req_s & (state_r == ST_SET_HOUR);

      if ((next_state_s == ST_RUN) | any_rise_s | repeat_due_s) begin
        idle_cnt_r <= {IDLE_W{1'b0}};
      end else if (idle_cnt_r != IDLE_LAST) begin
        idle_cnt_r <= idle_cnt_r + IDLE_W'(1'b1);
      end else begin
        idle_cnt_r <= idle_cnt_r;
      end

      // entering a set mode or adjusting shows the field immediately and restarts the blink phase
      if (next_state_s == ST_RUN) begin
        blink       <= 1'b1;
        blink_cnt_r <= {BLINK_W{1'b0}};
      end else if (mode_chg_s | inc_req_s) begin
        blink       <= 1'b1;
        blink_cnt_r <= {BLINK_W{1'b0}};
      end else if (blink_cnt_r == BLINK_LAST) begin
        blink       <= ~blink;
        blink_cnt_r <= {BLINK_W{1'b0}};
      end else begin
        blink_cnt_r <= blink_cnt_r + BLINK_W'(1'b1);
      end
    end
  end

endmodule

// File: tb/tb_clock_control_fsm.sv
// Self-checking bench for clock_control_fsm: constant vector table, hand sequences and
// randomized stimulus against a time-based reference model (honours AUTO_REPEAT_EN).
module tb_clock_control_fsm;
  localparam int unsigned TRD = 20;
  localparam int unsigned TRP = 5;
  localparam int unsigned TBL = 4;
  localparam int unsigned TID = 100;

  logic clk = 1'b0;
  logic rst, btn_run, btn_mode, btn_inc;
  logic start_timer, adjust_minutes, adjust_hours, blink;
  logic [1:0] mode;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clock_control_fsm #(
    .T_REPEAT_DELAY(TRD), .T_REPEAT_PERIOD(TRP), .T_BLINK(TBL), .T_IDLE(TID)
  ) dut (
    .clk(clk), .rst(rst), .btn_run(btn_run), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .start_timer(start_timer), .adjust_minutes(adjust_minutes), .adjust_hours(adjust_hours),
    .mode(mode), .blink(blink)
  );

  // Reference model: timestamps of the last restart events, not counters
  int unsigned m_cyc = 0;
  bit          m_fresh = 1'b1;
  bit          p_run = 1'b0, p_mode = 1'b0, p_inc = 1'b0;
  int          m_mode = 0;
  bit          m_run = 1'b0, m_armed = 1'b0, m_pulse_out = 1'b0;
  int unsigned m_t0 = 0, m_idle_ref = 0, m_blink_ref = 0;
  logic [5:0]  exp_vec = 6'b000001;

  task automatic model_step(input bit r, input bit run, input bit md, input bit inc);
    bit rr, rm, ri, rep, tout, pulse, bl;
    int nm;
    int unsigned age;
    if (r) begin
      m_fresh = 1'b1; p_run = 1'b0; p_mode = 1'b0; p_inc = 1'b0;
      m_mode = 0; m_run = 1'b0; m_armed = 1'b0; m_pulse_out = 1'b0;
      m_idle_ref = m_cyc; m_blink_ref = m_cyc;
      exp_vec = 6'b000001;
    end else begin
      rr = !m_fresh && run && !p_run;
      rm = !m_fresh && md && !p_mode;
      ri = !m_fresh && inc && !p_inc;
      p_run = run; p_mode = md; p_inc = inc; m_fresh = 1'b0;
      rep = 1'b0;
`ifdef AUTO_REPEAT_EN
      if (m_mode != 0 && m_armed && inc && !ri) begin
        age = m_cyc + 1 - m_t0;
        rep = (age >= TRD) && (((age - TRD) % TRP) == 0);
      end
`endif
      tout  = (m_mode != 0) && !(rr || rm || ri) && !rep && ((m_cyc - m_idle_ref) >= TID);
      nm    = rm ? ((m_mode + 1) % 3) : (tout ? 0 : m_mode);
      pulse = (m_mode != 0) && !rm && (ri || rep) && !m_pulse_out;
      if (m_mode == 0 && rr) m_run = !m_run;
      if (pulse && ri) begin
        m_armed = 1'b1;
        m_t0 = m_cyc + 1;
      end else if (nm != m_mode || !inc) begin
        m_armed = 1'b0;
      end
      if (nm == 0 || rr || rm || ri || rep) m_idle_ref = m_cyc;
      if (nm != m_mode || pulse) m_blink_ref = m_cyc;
      bl = (nm == 0) ? 1'b1 : ((((m_cyc - m_blink_ref) / TBL) % 2) == 0);
      exp_vec = {m_run && (nm == 0), pulse && (m_mode == 1), pulse && (m_mode == 2), 2'(nm), bl};
      m_pulse_out = pulse;
      m_mode = nm;
    end
    m_cyc++;
  endtask

  task automatic check_vec(input string nm, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {start,adjm,adjh,mode,blink}=%b expected %b", nm, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {start_timer, adjust_minutes, adjust_hours, mode, blink};
  endfunction

  // Drive one cycle of inputs, let the edge pass, compare against the model
  task automatic step(input logic r, input logic run, input logic md, input logic inc);
    rst = r; btn_run = run; btn_mode = md; btn_inc = inc;
    model_step(r, run, md, inc);
    @(posedge clk);
    #1;
    check_vec($sformatf("model@%0d", m_cyc), outs(), exp_vec);
  endtask

  typedef struct {
    logic       r, run, md, inc;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, input logic run, input logic md, input logic inc, input logic [5:0] e);
    vec_t v;
    v.r = r; v.run = run; v.md = md; v.inc = inc; v.exp = e;
    vecs.push_back(v);
  endtask

  int exp_off[5];
  int exp_n;
  int got_off[$];
  int tout_i;
  logic st_at_tout;
  bit lv_run, lv_mode, lv_inc;

  initial begin
    rst = 1'b1; btn_run = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;

    //   rst run md inc   {start,adjm,adjh,mode,blink}
    add(1'b1, 1'b0, 1'b0, 1'b0, 6'b000001);
    add(1'b1, 1'b0, 1'b0, 1'b0, 6'b000001);
    add(1'b1, 1'b0, 1'b0, 1'b0, 6'b000001);
    add(1'b0, 1'b0, 1'b0, 1'b0, 6'b000001);
    add(1'b0, 1'b1, 1'b0, 1'b0, 6'b100001);  // run rise -> running
    add(1'b0, 1'b0, 1'b0, 1'b0, 6'b100001);
    add(1'b0, 1'b0, 1'b1, 1'b0, 6'b000011);  // SET_MIN freezes the clock
    add(1'b0, 1'b0, 1'b0, 1'b1, 6'b010011);  // minute pulse one cycle later
    add(1'b0, 1'b0, 1'b0, 1'b0, 6'b000011);
    add(1'b0, 1'b0, 1'b0, 1'b0, 6'b000011);
    add(1'b0, 1'b0, 1'b0, 1'b0, 6'b000011);
    add(1'b0, 1'b0, 1'b0, 1'b0, 6'b000010);  // blink off after T_BLINK cycles
    add(1'b0, 1'b0, 1'b1, 1'b1, 6'b000101);  // mode + inc together: mode wins
    add(1'b0, 1'b0, 1'b0, 1'b1, 6'b000101);
    add(1'b0, 1'b0, 1'b0, 1'b0, 6'b000101);
    add(1'b0, 1'b0, 1'b0, 1'b1, 6'b001101);  // hour pulse
    add(1'b0, 1'b0, 1'b0, 1'b0, 6'b000101);
    add(1'b0, 1'b0, 1'b1, 1'b0, 6'b100001);  // back to RUN, run flag restored
    add(1'b0, 1'b0, 1'b0, 1'b1, 6'b100001);  // inc in RUN: no pulse
    add(1'b0, 1'b1, 1'b0, 1'b0, 6'b000001);  // pause
    add(1'b0, 1'b0, 1'b0, 1'b0, 6'b000001);
    add(1'b1, 1'b1, 1'b0, 1'b0, 6'b000001);
    add(1'b0, 1'b1, 1'b0, 1'b0, 6'b000001);  // held at release: no edge
    add(1'b0, 1'b1, 1'b0, 1'b0, 6'b000001);
    add(1'b0, 1'b0, 1'b0, 1'b0, 6'b000001);
    add(1'b0, 1'b1, 1'b0, 1'b0, 6'b100001);
    add(1'b0, 1'b0, 1'b0, 1'b0, 6'b100001);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].run, vecs[i].md, vecs[i].inc);
      check_vec($sformatf("table[%0d]", i), outs(), vecs[i].exp);
    end

    // Held btn_inc in SET_HOUR: pulse offsets relative to the press cycle
`ifdef AUTO_REPEAT_EN
    exp_off[0] = 1; exp_off[1] = 21; exp_off[2] = 26; exp_off[3] = 31; exp_off[4] = 36; exp_n = 5;
`else
    exp_off[0] = 1; exp_off[1] = 0; exp_off[2] = 0; exp_off[3] = 0; exp_off[4] = 0; exp_n = 1;
`endif
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_vec("t3_in_set_hour", outs(), 6'b000101);
    for (int k = 0; k < 48; k++) begin
      step(1'b0, 1'b0, 1'b0, (k < 40) ? 1'b1 : 1'b0);
      if (adjust_hours) got_off.push_back(k + 1);
    end
    check_int("t3_pulse_count", got_off.size(), exp_n);
    for (int k = 0; k < exp_n; k++) begin
      if (k < got_off.size()) check_int($sformatf("t3_pulse_off[%0d]", k), got_off[k], exp_off[k]);
    end

    // Idle timeout from SET_MIN restores the running clock
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_vec("t4_enter_set_min", outs(), 6'b000011);
    tout_i = -1;
    st_at_tout = 1'b0;
    for (int i = 1; i <= 150; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (mode == 2'b00) begin
        tout_i = i;
        st_at_tout = start_timer;
        break;
      end
    end
    check_int("t4_timeout_cycle", tout_i, 100);
    check_int("t4_start_restored", int'(st_at_tout), 1);

    // Reset in the cycle a repeat would be due in SET_HOUR
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 25; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check_vec("t6_reset_mid_burst", outs(), 6'b000001);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_vec("t6_after_reset", outs(), 6'b000001);

    // Randomized levels against the model
    lv_run = 1'b0; lv_mode = 1'b0; lv_inc = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 19) == 0) lv_run = ~lv_run;
      if ($urandom_range(0, 39) == 0) lv_mode = ~lv_mode;
      if ($urandom_range(0, 29) == 0) lv_inc = ~lv_inc;
      step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, lv_run, lv_mode, lv_inc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
